rgb_seq_monitor: RTL and testbench

RGB_SEQ_MONITOR -- requirements
Module: rgb_seq_monitor

---
 rtl/rgb_pkg.sv | 38 +++
 rtl/rgb_dwell_counter.sv | 28 ++
 rtl/rgb_seq_monitor.sv | 145 ++++++++++++++
 tb/tb_rgb_seq_monitor.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared types for the RGB sequence monitor.
// Colour decode, monitor states and error cause codes.
package rgb_pkg;

    typedef enum logic [2:0] {
        BLANK,
        RED,
        GREEN,
        BLUE,
        ILLEGAL
    } colour_e;

    typedef enum logic [2:0] {
        IDLE,
        RED_S,
        GREEN_S,
        BLUE_S,
        RESYNC
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ORDER   = 2'b01;
    localparam logic [1:0] ERR_TIMING  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    function automatic colour_e decode(input logic r, input logic g, input logic b);
        colour_e c;
        case ({r, g, b})
            3'b000:  c = BLANK;
            3'b100:  c = RED;
            3'b010:  c = GREEN;
            3'b001:  c = BLUE;
            default: c = ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rgb_dwell_counter.sv
// Counts consecutive samples of one colour.
// Restarts at 1 on a colour change and saturates at MAX.
module rgb_dwell_counter #(
    parameter int MAX = 10,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic change_i,
    output logic full_o
);

    logic [W-1:0] dwell_q;

    // Load 1 on change, otherwise count up until MAX is reached.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dwell_q <= '0;
        end else if (change_i) begin
            dwell_q <= W'(1);
        end else if (dwell_q != W'(MAX)) begin
            dwell_q <= dwell_q + W'(1);
        end
    end

    assign full_o = (dwell_q == W'(MAX));

endmodule

// File: rtl/rgb_seq_monitor.sv
// Watches RED->GREEN->BLUE->BLANK sequences with a fixed dwell per colour.
// Flags order, timing and illegal-colour violations; counts good sequences.
import rgb_pkg::*;

module rgb_seq_monitor #(
    parameter int COUNTER_MAX     = 10,
    parameter int SEQ_COUNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       red,
    input  logic                       green,
    input  logic                       blue,
    output logic                       seq_done,
    output logic                       error,
    output logic [1:0]                 err_code,
    output logic [SEQ_COUNT_WIDTH-1:0] seq_count,
    output logic                       busy
);

    colour_e sample_q;
    colour_e prev_q;
    state_e  state_q;
    state_e  state_d;
    logic    dwell_full;
    logic    err_set;
    logic    done_set;
    logic [1:0] err_kind;
    colour_e cur_c;
    colour_e nxt_c;
    state_e  nxt_s;

    logic                       seq_done_q;
    logic                       error_q;
    logic [1:0]                 err_code_q;
    logic [SEQ_COUNT_WIDTH-1:0] seq_count_q;
    logic                       busy_q;

    // Dwell counts samples already consumed by the FSM, so it lags sample_q.
    rgb_dwell_counter #(
        .MAX (COUNTER_MAX)
    ) u_dwell (
        .clk_i    (clk),
        .rst_i    (reset),
        .change_i (sample_q != prev_q),
        .full_o   (dwell_full)
    );

    // Current colour and the only legal successor for each busy state.
    always_comb begin
        cur_c = BLANK;
        nxt_c = BLANK;
        nxt_s = IDLE;
        case (state_q)
            RED_S:   begin cur_c = RED;   nxt_c = GREEN; nxt_s = GREEN_S; end
            GREEN_S: begin cur_c = GREEN; nxt_c = BLUE;  nxt_s = BLUE_S;  end
            BLUE_S:  begin cur_c = BLUE;  nxt_c = BLANK; nxt_s = IDLE;    end
            default: ;
        endcase
    end

    // Next-state decision; checks are mutually exclusive, which gives illegal > order > timing.
    always_comb begin
        state_d  = state_q;
        err_set  = 1'b0;
        err_kind = ERR_NONE;
        done_set = 1'b0;
        case (state_q)
            IDLE: begin
                case (sample_q)
                    BLANK:   ;
                    RED:     state_d = RED_S;
                    ILLEGAL: begin err_set = 1'b1; err_kind = ERR_ILLEGAL; end
                    default: begin err_set = 1'b1; err_kind = ERR_ORDER;   end
                endcase
            end
            RED_S, GREEN_S, BLUE_S: begin
                if (sample_q == ILLEGAL) begin
                    err_set  = 1'b1;
                    err_kind = ERR_ILLEGAL;
                end else if (sample_q == cur_c) begin
                    if (dwell_full) begin
                        err_set  = 1'b1;
                        err_kind = ERR_TIMING;
                    end
                end else if (sample_q == nxt_c) begin
                    if (dwell_full) begin
                        state_d  = nxt_s;
                        done_set = (state_q == BLUE_S);
                    end else begin
                        err_set  = 1'b1;
                        err_kind = ERR_TIMING;
                    end
                end else begin
                    err_set  = 1'b1;
                    err_kind = ERR_ORDER;
                end
            end
            RESYNC: begin
                if (sample_q == BLANK) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (err_set) begin
            state_d = RESYNC;
        end
    end

    // Sample stage, FSM state and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q    <= BLANK;
            prev_q      <= BLANK;
            state_q     <= IDLE;
            seq_done_q  <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            seq_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            sample_q   <= decode(red, green, blue);
            prev_q     <= sample_q;
            state_q    <= state_d;
            seq_done_q <= done_set;
            error_q    <= err_set;
            busy_q     <= (state_d == RED_S) || (state_d == GREEN_S) ||
                          (state_d == BLUE_S);
            if (err_set) begin
                err_code_q <= err_kind;
            end
            if (done_set && (seq_count_q != '1)) begin
                seq_count_q <= seq_count_q + SEQ_COUNT_WIDTH'(1);
            end
        end
    end

    assign seq_done  = seq_done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign seq_count = seq_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rgb_seq_monitor.sv
// Directed bench for rgb_seq_monitor with COUNTER_MAX=4.
// Each task drives one scenario and checks its own expected values.
module tb_rgb_seq_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       red;
    logic       green;
    logic       blue;
    logic       seq_done;
    logic       error;
    logic [1:0] err_code;
    logic [7:0] seq_count;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    localparam logic [2:0] Z = 3'b000;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] B = 3'b001;
    localparam logic [2:0] X = 3'b110;

    rgb_seq_monitor #(
        .COUNTER_MAX     (4),
        .SEQ_COUNT_WIDTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .seq_done  (seq_done),
        .error     (error),
        .err_code  (err_code),
        .seq_count (seq_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One clock cycle with the given colour on the lines.
    task automatic cyc(input logic [2:0] v);
        {red, green, blue} = v;
        @(posedge clk);
        #1;
        done_cnt += int'(seq_done);
        err_cnt  += int'(error);
    endtask

    task automatic run(input logic [2:0] v, input int n);
        repeat (n) cyc(v);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        {red, green, blue} = Z;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        done_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++;
        if ({seq_done, error, err_code, seq_count, busy} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got %b want 0",
                     {seq_done, error, err_code, seq_count, busy});
        end
    endtask

    task automatic test_legal;
        do_reset();
        run(Z, 3);
        cyc(R);
        cyc(R);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL legal_busy got %b want 1", busy);
        end
        run(R, 2);
        run(G, 4);
        run(B, 4);
        cyc(Z);
        n_cmp++;
        if (seq_done !== 1'b0) begin
            n_bad++;
            $display("FAIL legal_done_early got %b want 0", seq_done);
        end
        cyc(Z);
        n_cmp++;
        if (seq_done !== 1'b1) begin
            n_bad++;
            $display("FAIL legal_done got %b want 1", seq_done);
        end
        n_cmp++;
        if (seq_count !== 8'd1) begin
            n_bad++;
            $display("FAIL legal_count got %0d want 1", seq_count);
        end
        run(Z, 3);
        n_cmp++;
        if (done_cnt !== 1 || err_cnt !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL legal_totals got done=%0d err=%0d busy=%b want 1 0 0",
                     done_cnt, err_cnt, busy);
        end
    endtask

    task automatic test_early_change;
        do_reset();
        cyc(Z);
        run(R, 3);
        cyc(G);
        cyc(G);
        n_cmp++;
        if (error !== 1'b1 || err_code !== 2'b10 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL early_err got err=%b code=%b busy=%b want 1 10 0",
                     error, err_code, busy);
        end
        cyc(G);
        n_cmp++;
        if (error !== 1'b0) begin
            n_bad++;
            $display("FAIL early_pulse got %b want 0", error);
        end
        run(Z, 3);
        n_cmp++;
        if (done_cnt !== 0 || err_cnt !== 1) begin
            n_bad++;
            $display("FAIL early_totals got done=%0d err=%0d want 0 1",
                     done_cnt, err_cnt);
        end
    endtask

    task automatic test_overdwell;
        do_reset();
        cyc(Z);
        run(R, 5);
        n_cmp++;
        if (error !== 1'b0) begin
            n_bad++;
            $display("FAIL overdwell_early got %b want 0", error);
        end
        cyc(Z);
        n_cmp++;
        if (error !== 1'b1 || err_code !== 2'b10) begin
            n_bad++;
            $display("FAIL overdwell_err got err=%b code=%b want 1 10",
                     error, err_code);
        end
        run(Z, 3);
        n_cmp++;
        if (err_cnt !== 1 || done_cnt !== 0) begin
            n_bad++;
            $display("FAIL overdwell_totals got err=%0d done=%0d want 1 0",
                     err_cnt, done_cnt);
        end
    endtask

    task automatic test_order_illegal;
        do_reset();
        cyc(Z);
        cyc(G);
        cyc(Z);
        n_cmp++;
        if (error !== 1'b1 || err_code !== 2'b01) begin
            n_bad++;
            $display("FAIL order_err got err=%b code=%b want 1 01", error, err_code);
        end
        cyc(Z);
        cyc(X);
        cyc(X);
        n_cmp++;
        if (error !== 1'b1 || err_code !== 2'b11) begin
            n_bad++;
            $display("FAIL illegal_err got err=%b code=%b want 1 11", error, err_code);
        end
        cyc(X);
        n_cmp++;
        if (error !== 1'b0 || err_code !== 2'b11) begin
            n_bad++;
            $display("FAIL illegal_suppress got err=%b code=%b want 0 11",
                     error, err_code);
        end
        run(Z, 3);
        n_cmp++;
        if (err_cnt !== 2 || err_code !== 2'b11) begin
            n_bad++;
            $display("FAIL order_totals got err=%0d code=%b want 2 11",
                     err_cnt, err_code);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        cyc(Z);
        for (int i = 0; i < 300; i++) begin
            run(R, 4);
            run(G, 4);
            run(B, 4);
            cyc(Z);
        end
        run(Z, 3);
        n_cmp++;
        if (seq_count !== 8'd255) begin
            n_bad++;
            $display("FAIL b2b_count got %0d want 255", seq_count);
        end
        n_cmp++;
        if (done_cnt !== 300 || err_cnt !== 0) begin
            n_bad++;
            $display("FAIL b2b_pulses got done=%0d err=%0d want 300 0",
                     done_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_mid;
        cyc(Z);
        run(R, 4);
        run(G, 3);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_busy got %b want 1", busy);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({seq_done, error, err_code, seq_count, busy} !== 13'd0) begin
            n_bad++;
            $display("FAIL mid_reset got %b want 0",
                     {seq_done, error, err_code, seq_count, busy});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        done_cnt = 0;
        err_cnt = 0;
        cyc(Z);
        run(R, 4);
        run(G, 4);
        run(B, 4);
        run(Z, 4);
        n_cmp++;
        if (seq_count !== 8'd1 || done_cnt !== 1 || err_cnt !== 0) begin
            n_bad++;
            $display("FAIL mid_after got cnt=%0d done=%0d err=%0d want 1 1 0",
                     seq_count, done_cnt, err_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        {red, green, blue} = Z;
        test_reset();
        test_legal();
        test_early_change();
        test_overdwell();
        test_order_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
